mem_port_arbiter: RTL and testbench

Shares one pipelined 16-bit word memory port between the CPU's instruction-fetch port and its load/store port. Sits between the datapath's `o_pc_*` / `o_ldst_*` bus outputs and the single memory. Issues at most one access per cycle and stalls the losing stage. Returns read data to the correct requester with fixed latency.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_starve_cnt.sv | 35 +++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Build option: define MEM_ARB_FAIRNESS_EN to compile in the fetch starvation guard.
package mem_arb_pkg;

  localparam int unsigned WordWidth = 16;

  // Grant FSM: FREE arbitrates, HOLD_x keeps the port on x until the memory accepts.
  typedef enum logic [1:0] {
    FREE      = 2'd0,
    HOLD_PC   = 2'd1,
    HOLD_LDST = 2'd2
  } arb_state_t;

  // Which requester an in-flight read belongs to.
  typedef enum logic {
    OWN_PC   = 1'b0,
    OWN_LDST = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Fetch starvation counter: counts load/store wins while fetch waits, saturating at
// STARVE_LIMIT. Only instantiated when MEM_ARB_FAIRNESS_EN is defined.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] r_cnt;

  // Clear on a fetch acceptance, otherwise count ldst wins up to the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt != Limit)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Limit reached: fetch must win the next free arbitration.
  always_comb begin
    o_at_limit = (r_cnt == Limit);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined word memory port between instruction fetch and load/store.
// Load/store has fixed priority; a granted command is held until the memory accepts it.
// Read data returns to its owner two cycles after acceptance.
// Build option: MEM_ARB_FAIRNESS_EN adds a forced fetch win after STARVE_LIMIT ldst wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  // Fetch port
  input  logic [WordWidth-1:0] i_pc_addr,
  input  logic                 i_pc_rd,
  output logic                 o_pc_stall,
  output logic [WordWidth-1:0] o_pc_rddata,
  output logic                 o_pc_valid,
  // Load/store port
  input  logic [WordWidth-1:0] i_ldst_addr,
  input  logic                 i_ldst_rd,
  input  logic                 i_ldst_wr,
  input  logic [WordWidth-1:0] i_ldst_wrdata,
  output logic                 o_ldst_stall,
  output logic [WordWidth-1:0] o_ldst_rddata,
  output logic                 o_ldst_valid,
  // Memory port
  output logic [WordWidth-1:0] o_mem_addr,
  output logic                 o_mem_rd,
  output logic                 o_mem_wr,
  output logic [WordWidth-1:0] o_mem_wrdata,
  input  logic [WordWidth-1:0] i_mem_rddata,
  input  logic                 i_mem_waitrequest
);

  arb_state_t           r_st;
  logic                 r_rsp_vld;
  arb_owner_t           r_rsp_own;
  logic                 r_pc_valid;
  logic                 r_ldst_valid;
  logic [WordWidth-1:0] r_pc_rddata;
  logic [WordWidth-1:0] r_ldst_rddata;

  logic w_pc_req;
  logic w_ldst_req;
  logic w_grant_pc;
  logic w_grant_ldst;
  logic w_acc_pc;
  logic w_acc_ldst;
  logic w_mem_rd;
  logic w_force_pc;
  logic w_starve_inc;

  assign w_pc_req   = i_pc_rd;
  assign w_ldst_req = i_ldst_rd | i_ldst_wr;

`ifdef MEM_ARB_FAIRNESS_EN
  assign w_starve_inc = w_pc_req & w_acc_ldst;

  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_starve_inc),
    .i_clr     (w_acc_pc),
    .o_at_limit(w_force_pc)
  );
`else
  // Strict ldst priority: the limit has no effect in this build.
  logic w_unused_limit;
  assign w_unused_limit = (STARVE_LIMIT != 0);
  assign w_starve_inc   = 1'b0;
  assign w_force_pc     = 1'b0;
`endif

  // Grant decision: nothing is granted while reset is asserted.
  always_comb begin
    w_grant_pc   = 1'b0;
    w_grant_ldst = 1'b0;
    if (!reset) begin
      unique case (r_st)
        FREE: begin
          if (w_ldst_req && !(w_force_pc && w_pc_req)) begin
            w_grant_ldst = 1'b1;
          end else if (w_pc_req) begin
            w_grant_pc = 1'b1;
          end
        end
        HOLD_PC:   w_grant_pc   = 1'b1;
        HOLD_LDST: w_grant_ldst = 1'b1;
        default: ;
      endcase
    end
  end

  // Memory command, acceptance and per-port stall.
  always_comb begin
    w_acc_pc     = w_grant_pc & ~i_mem_waitrequest;
    w_acc_ldst   = w_grant_ldst & ~i_mem_waitrequest;
    // Rd and wr together on ldst is a store; the read half is dropped.
    w_mem_rd     = w_grant_pc | (w_grant_ldst & i_ldst_rd & ~i_ldst_wr);
    o_mem_rd     = w_mem_rd;
    o_mem_wr     = w_grant_ldst & i_ldst_wr;
    o_mem_addr   = w_grant_ldst ? i_ldst_addr : i_pc_addr;
    o_mem_wrdata = i_ldst_wrdata;
    o_pc_stall   = w_pc_req & ~w_acc_pc;
    o_ldst_stall = w_ldst_req & ~w_acc_ldst;
  end

  // Grant FSM: lock onto the winner while the memory pushes back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st <= FREE;
    end else if (w_grant_pc && i_mem_waitrequest) begin
      r_st <= HOLD_PC;
    end else if (w_grant_ldst && i_mem_waitrequest) begin
      r_st <= HOLD_LDST;
    end else begin
      r_st <= FREE;
    end
  end

  // Response pipe stage 1: remember who owns the read accepted this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_vld <= 1'b0;
      r_rsp_own <= OWN_PC;
    end else begin
      r_rsp_vld <= w_mem_rd & ~i_mem_waitrequest;
      r_rsp_own <= w_grant_ldst ? OWN_LDST : OWN_PC;
    end
  end

  // Response pipe stage 2: steer returning data to its owner, pulse valid once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_valid    <= 1'b0;
      r_ldst_valid  <= 1'b0;
      r_pc_rddata   <= '0;
      r_ldst_rddata <= '0;
    end else begin
      r_pc_valid   <= r_rsp_vld && (r_rsp_own == OWN_PC);
      r_ldst_valid <= r_rsp_vld && (r_rsp_own == OWN_LDST);
      if (r_rsp_vld && (r_rsp_own == OWN_PC)) begin
        r_pc_rddata <= i_mem_rddata;
      end
      if (r_rsp_vld && (r_rsp_own == OWN_LDST)) begin
        r_ldst_rddata <= i_mem_rddata;
      end
    end
  end

  assign o_pc_valid    = r_pc_valid;
  assign o_pc_rddata   = r_pc_rddata;
  assign o_ldst_valid  = r_ldst_valid;
  assign o_ldst_rddata = r_ldst_rddata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes expected read responses into
// per-port queues; a monitor pops and compares on every valid pulse.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] i_pc_addr;
  logic        i_pc_rd;
  logic        o_pc_stall;
  logic [15:0] o_pc_rddata;
  logic        o_pc_valid;
  logic [15:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_wrdata;
  logic        o_ldst_stall;
  logic [15:0] o_ldst_rddata;
  logic        o_ldst_valid;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [15:0] o_mem_wrdata;
  logic [15:0] i_mem_rddata;
  logic        i_mem_waitrequest;

  int          n_vec;
  int          n_bad;
  logic [15:0] exp_pc_q[$];
  logic [15:0] exp_ld_q[$];

  mem_port_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_pc_addr        (i_pc_addr),
    .i_pc_rd          (i_pc_rd),
    .o_pc_stall       (o_pc_stall),
    .o_pc_rddata      (o_pc_rddata),
    .o_pc_valid       (o_pc_valid),
    .i_ldst_addr      (i_ldst_addr),
    .i_ldst_rd        (i_ldst_rd),
    .i_ldst_wr        (i_ldst_wr),
    .i_ldst_wrdata    (i_ldst_wrdata),
    .o_ldst_stall     (o_ldst_stall),
    .o_ldst_rddata    (o_ldst_rddata),
    .o_ldst_valid     (o_ldst_valid),
    .o_mem_addr       (o_mem_addr),
    .o_mem_rd         (o_mem_rd),
    .o_mem_wr         (o_mem_wr),
    .o_mem_wrdata     (o_mem_wrdata),
    .i_mem_rddata     (i_mem_rddata),
    .i_mem_waitrequest(i_mem_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pc_rd, input logic [15:0] pc_a, input logic ld_rd,
                       input logic ld_wr, input logic [15:0] ld_a, input logic [15:0] ld_wd,
                       input logic wreq);
    i_pc_rd           = pc_rd;
    i_pc_addr         = pc_a;
    i_ldst_rd         = ld_rd;
    i_ldst_wr         = ld_wr;
    i_ldst_addr       = ld_a;
    i_ldst_wrdata     = ld_wd;
    i_mem_waitrequest = wreq;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: a read accepted in cycle T returns 0xA000+addr during T+1.
  initial begin
    logic        w;
    logic [15:0] a;
    i_mem_rddata = 16'hDEAD;
    forever begin
      @(negedge clk);
      w = o_mem_rd && !i_mem_waitrequest;
      a = o_mem_addr;
      @(posedge clk);
      #1;
      i_mem_rddata = w ? (16'hA000 + a) : 16'hDEAD;
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (o_pc_valid) begin
        if (exp_pc_q.size() == 0) chk("pc_valid_unexpected", 16'd1, 16'd0);
        else chk("pc_rddata", o_pc_rddata, exp_pc_q.pop_front());
      end
      if (o_ldst_valid) begin
        if (exp_ld_q.size() == 0) chk("ldst_valid_unexpected", 16'd1, 16'd0);
        else chk("ldst_rddata", o_ldst_rddata, exp_ld_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    idle();
    tick();

    // Reset state: no grant, stall mirrors request, outputs cleared.
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0);
    #3;
    chk("rst_pc_stall", o_pc_stall, 16'd1);
    chk("rst_ldst_stall", o_ldst_stall, 16'd1);
    chk("rst_mem_rd", o_mem_rd, 16'd0);
    chk("rst_mem_wr", o_mem_wr, 16'd0);
    chk("rst_pc_valid", o_pc_valid, 16'd0);
    chk("rst_ldst_valid", o_ldst_valid, 16'd0);
    chk("rst_pc_rddata", o_pc_rddata, 16'h0000);
    chk("rst_ldst_rddata", o_ldst_rddata, 16'h0000);
    idle();
    tick();
    reset = 1'b0;
    tick();

    // Fetch-only back-to-back reads.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0010 + 16'(k), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      #3;
      chk("f_pc_stall", o_pc_stall, 16'd0);
      chk("f_mem_rd", o_mem_rd, 16'd1);
      chk("f_mem_addr", o_mem_addr, 16'h0010 + 16'(k));
      chk("f_pc_valid_early", o_pc_valid, (k == 2) ? 16'd1 : 16'd0);
      exp_pc_q.push_back(16'hA010 + 16'(k));
      tick();
    end
    idle();
    #3;
    chk("f_pc_valid_t3", o_pc_valid, 16'd1);
    tick();
    #3;
    chk("f_pc_valid_t4", o_pc_valid, 16'd1);
    tick();
    #3;
    chk("f_pc_valid_t5", o_pc_valid, 16'd0);
    chk("f_pc_rddata_hold", o_pc_rddata, 16'hA012);
    tick();

    // Contention: store wins, fetch stalls one cycle.
    drive(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0);
    #3;
    chk("c_mem_wr", o_mem_wr, 16'd1);
    chk("c_mem_rd", o_mem_rd, 16'd0);
    chk("c_mem_addr", o_mem_addr, 16'h0100);
    chk("c_mem_wrdata", o_mem_wrdata, 16'hBEEF);
    chk("c_pc_stall", o_pc_stall, 16'd1);
    chk("c_ldst_stall", o_ldst_stall, 16'd0);
    tick();
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #3;
    chk("c2_mem_rd", o_mem_rd, 16'd1);
    chk("c2_mem_addr", o_mem_addr, 16'h0020);
    chk("c2_pc_stall", o_pc_stall, 16'd0);
    exp_pc_q.push_back(16'hA020);
    tick();
    idle();
    tick();
    tick();

    // Waitrequest lock on fetch while ldst arrives.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0030, (k > 0), 1'b0, 16'h0200, 16'h0, 1'b1);
      #3;
      chk("w_mem_addr", o_mem_addr, 16'h0030);
      chk("w_mem_rd", o_mem_rd, 16'd1);
      chk("w_pc_stall", o_pc_stall, 16'd1);
      chk("w_ldst_stall", o_ldst_stall, (k > 0) ? 16'd1 : 16'd0);
      tick();
    end
    drive(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0);
    #3;
    chk("w_acc_addr", o_mem_addr, 16'h0030);
    chk("w_acc_pc_stall", o_pc_stall, 16'd0);
    chk("w_acc_ldst_stall", o_ldst_stall, 16'd1);
    exp_pc_q.push_back(16'hA030);
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0);
    #3;
    chk("w_ld_addr", o_mem_addr, 16'h0200);
    chk("w_ld_rd", o_mem_rd, 16'd1);
    chk("w_ld_stall", o_ldst_stall, 16'd0);
    exp_ld_q.push_back(16'hA200);
    tick();
    idle();
    tick();
    tick();

    // Load burst with fetch waiting.
`ifdef MEM_ARB_FAIRNESS_EN
    cur = 16'h0300;
    for (int k = 0; k < 7; k++) begin
      drive((k <= 4), 16'h0040, 1'b1, 1'b0, cur, 16'h0, 1'b0);
      #3;
      if (k == 4) begin
        chk("fair_pc_stall", o_pc_stall, 16'd0);
        chk("fair_ldst_stall", o_ldst_stall, 16'd1);
        chk("fair_addr", o_mem_addr, 16'h0040);
        exp_pc_q.push_back(16'hA040);
      end else begin
        chk("fair_ld_stall", o_ldst_stall, 16'd0);
        chk("fair_pc_wait", o_pc_stall, (k < 4) ? 16'd1 : 16'd0);
        chk("fair_ld_addr", o_mem_addr, cur);
        exp_ld_q.push_back(16'hA000 + cur);
        cur = cur + 16'd1;
      end
      tick();
    end
`else
    cur = 16'h0300;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 16'h0040, 1'b1, 1'b0, cur, 16'h0, 1'b0);
      #3;
      chk("prio_pc_stall", o_pc_stall, 16'd1);
      chk("prio_ld_stall", o_ldst_stall, 16'd0);
      chk("prio_ld_addr", o_mem_addr, cur);
      exp_ld_q.push_back(16'hA000 + cur);
      cur = cur + 16'd1;
      tick();
    end
    drive(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #3;
    chk("prio_pc_go", o_pc_stall, 16'd0);
    chk("prio_pc_addr", o_mem_addr, 16'h0040);
    exp_pc_q.push_back(16'hA040);
    tick();
`endif
    idle();
    tick();
    tick();
    tick();

    // Reset in the cycle after a load is accepted: response must vanish.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0400, 16'h0, 1'b0);
    #3;
    chk("r_ld_stall", o_ldst_stall, 16'd0);
    chk("r_ld_rd", o_mem_rd, 16'd1);
    tick();
    drive(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    reset = 1'b1;
    #3;
    chk("r_pc_stall_in_rst", o_pc_stall, 16'd1);
    chk("r_mem_rd_in_rst", o_mem_rd, 16'd0);
    chk("r_ldst_valid", o_ldst_valid, 16'd0);
    tick();
    idle();
    chk("r_ldst_valid2", o_ldst_valid, 16'd0);
    chk("r_ldst_rddata", o_ldst_rddata, 16'h0000);
    reset = 1'b0;
    tick();
    #3;
    chk("r_ldst_valid3", o_ldst_valid, 16'd0);
    chk("r_ldst_rddata2", o_ldst_rddata, 16'h0000);
    tick();

    // Rd and wr both high on ldst: treated as a store, no response.
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0500, 16'h1234, 1'b0);
    #3;
    chk("rw_mem_wr", o_mem_wr, 16'd1);
    chk("rw_mem_rd", o_mem_rd, 16'd0);
    chk("rw_mem_addr", o_mem_addr, 16'h0500);
    chk("rw_mem_wrdata", o_mem_wrdata, 16'h1234);
    chk("rw_ldst_stall", o_ldst_stall, 16'd0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();

    chk("pc_q_drained", 16'(exp_pc_q.size()), 16'd0);
    chk("ld_q_drained", 16'(exp_ld_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
